// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package mips_mc_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      RTYPEEX,
      RTYPEWB,
      BEQEX,
      ADDIEX,
      ADDIWB,
      JEX,
      BNEEX
   } state_t;

   // ALU operation class requested by the FSM; FUNCT defers to the funct field.
   typedef enum logic [1:0] {
      ADD,
      SUB,
      FUNCT
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_mc_alu_decoder.sv
// Maps the FSM's ALU operation class plus funct onto the 3-bit ALU control.
module mips_mc_alu_decoder
   import mips_mc_pkg::*;
(
   input  alu_op_t     alu_op,
   input  logic [5:0]  funct,
   output logic [2:0]  alu_ctrl
);

   // Unknown funct codes fall back to add rather than flagging an error.
   always_comb begin
      alu_ctrl = ALU_ADD;
      case (alu_op)
         SUB:     alu_ctrl = ALU_SUB;
         FUNCT: begin
            case (funct)
               FN_ADD:  alu_ctrl = ALU_ADD;
               FN_SUB:  alu_ctrl = ALU_SUB;
               FN_AND:  alu_ctrl = ALU_AND;
               FN_OR:   alu_ctrl = ALU_OR;
               FN_SLT:  alu_ctrl = ALU_SLT;
               default: alu_ctrl = ALU_ADD;
            endcase
         end
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Control FSM for a multicycle MIPS core with a unified instruction/data memory.
// Optional feature macro: MIPS_MC_BNE_EN adds the bne instruction (BNEEX state).
module mips_multicycle_controller
   import mips_mc_pkg::*;
#(
   parameter int unsigned RESET_PC_HOLD = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_en,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic       reg_write,
   output logic       reg_dest,
   output logic       mem_to_reg,
   output logic       instr_done,
   output logic       illegal_op
);

   localparam logic [3:0] HoldInit = 4'(RESET_PC_HOLD);

   state_t     state_q, state_d;
   logic [3:0] hold_q, hold_d;

   alu_op_t    alu_op;
   logic [2:0] alu_ctrl_s;
   logic       mem_req_s, mem_write_s, i_or_d_s, ir_write_s, pc_write;
   logic       branch_eq, branch_ne;
   logic [1:0] pc_src_s, alu_src_b_s;
   logic       alu_src_a_s, reg_write_s, reg_dest_s, mem_to_reg_s;
   logic       instr_done_s, illegal_op_s;

   // State register and post-reset hold counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
         hold_q  <= HoldInit;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state and per-state datapath controls.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      alu_op       = ADD;
      mem_req_s    = 1'b0;
      mem_write_s  = 1'b0;
      i_or_d_s     = 1'b0;
      ir_write_s   = 1'b0;
      pc_write     = 1'b0;
      branch_eq    = 1'b0;
      branch_ne    = 1'b0;
      pc_src_s     = 2'b00;
      alu_src_a_s  = 1'b0;
      alu_src_b_s  = 2'b00;
      reg_write_s  = 1'b0;
      reg_dest_s   = 1'b0;
      mem_to_reg_s = 1'b0;
      instr_done_s = 1'b0;
      illegal_op_s = 1'b0;
      case (state_q)
         FETCH: begin
            if (hold_q != 4'd0) begin
               hold_d = hold_q - 4'd1;
            end else begin
               mem_req_s   = 1'b1;
               alu_src_b_s = 2'b01;
               if (mem_ready) begin
                  ir_write_s = 1'b1;
                  pc_write   = 1'b1;
                  state_d    = DECODE;
               end
            end
         end
         DECODE: begin
            // Precompute the branch target while the opcode is decoded.
            alu_src_b_s = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JEX;
`ifdef MIPS_MC_BNE_EN
               OP_BNE:       state_d = BNEEX;
`endif
               default: begin
                  illegal_op_s = 1'b1;
                  instr_done_s = 1'b1;
                  state_d      = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = 2'b10;
            state_d     = (op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            mem_req_s = 1'b1;
            i_or_d_s  = 1'b1;
            if (mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            reg_write_s  = 1'b1;
            mem_to_reg_s = 1'b1;
            instr_done_s = 1'b1;
            state_d      = FETCH;
         end
         MEMWR: begin
            mem_req_s   = 1'b1;
            mem_write_s = 1'b1;
            i_or_d_s    = 1'b1;
            if (mem_ready) begin
               instr_done_s = 1'b1;
               state_d      = FETCH;
            end
         end
         RTYPEEX: begin
            alu_src_a_s = 1'b1;
            alu_op      = FUNCT;
            state_d     = RTYPEWB;
         end
         RTYPEWB: begin
            reg_write_s  = 1'b1;
            reg_dest_s   = 1'b1;
            instr_done_s = 1'b1;
            state_d      = FETCH;
         end
         BEQEX: begin
            alu_src_a_s  = 1'b1;
            alu_op       = SUB;
            pc_src_s     = 2'b01;
            branch_eq    = 1'b1;
            instr_done_s = 1'b1;
            state_d      = FETCH;
         end
`ifdef MIPS_MC_BNE_EN
         BNEEX: begin
            alu_src_a_s  = 1'b1;
            alu_op       = SUB;
            pc_src_s     = 2'b01;
            branch_ne    = 1'b1;
            instr_done_s = 1'b1;
            state_d      = FETCH;
         end
`endif
         ADDIEX: begin
            alu_src_a_s = 1'b1;
            alu_src_b_s = 2'b10;
            state_d     = ADDIWB;
         end
         ADDIWB: begin
            reg_write_s  = 1'b1;
            instr_done_s = 1'b1;
            state_d      = FETCH;
         end
         JEX: begin
            pc_src_s     = 2'b10;
            pc_write     = 1'b1;
            instr_done_s = 1'b1;
            state_d      = FETCH;
         end
         // Unused encodings (and BNEEX when bne is disabled) recover to FETCH.
         default: state_d = FETCH;
      endcase
   end

   mips_mc_alu_decoder u_alu_decoder (
      .alu_op   (alu_op),
      .funct    (funct),
      .alu_ctrl (alu_ctrl_s)
   );

   // Outputs are forced low combinationally while reset is held.
   always_comb begin
      mem_req    = reset & mem_req_s;
      mem_write  = reset & mem_write_s;
      i_or_d     = reset & i_or_d_s;
      ir_write   = reset & ir_write_s;
      pc_en      = reset & (pc_write | (branch_eq & zero) | (branch_ne & ~zero));
      pc_src     = reset ? pc_src_s : 2'b00;
      alu_src_a  = reset & alu_src_a_s;
      alu_src_b  = reset ? alu_src_b_s : 2'b00;
      alu_ctrl   = reset ? alu_ctrl_s : 3'b000;
      reg_write  = reset & reg_write_s;
      reg_dest   = reset & reg_dest_s;
      mem_to_reg = reset & mem_to_reg_s;
      instr_done = reset & instr_done_s;
      illegal_op = reset & illegal_op_s;
   end

endmodule
